// File: rtl/ternary_matvec_engine.sv
// ============================================================================
// ternary_matvec_engine : column-serial ternary matrix x fixed-point vector
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package config_pkg;
  localparam int D                             = 4;
  localparam int FixedPointWidth               = 16;
  localparam int FixedPointFractionalPrecision = 8;
endpackage

module ternary_matvec_engine #(
  parameter int D        = config_pkg::D,
  parameter bit Saturate = 1'b1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           in_valid_i,
  output logic                                           in_ready_o,
  input  logic [D-1:0][config_pkg::FixedPointWidth-1:0]  in_vector_i,
  input  logic [D-1:0][D-1:0][1:0]                       in_matrix_i,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i,
  output logic [D-1:0][config_pkg::FixedPointWidth-1:0]  out_vector_o,
  output logic                                           illegal_o
);

  localparam int W  = config_pkg::FixedPointWidth;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = W + $clog2(D) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Two's-complement trit encoding; 2'b10 (-2) is the illegal code.
  localparam logic [1:0] T_POS = 2'b01;
  localparam logic [1:0] T_NEG = 2'b11;
  localparam logic [1:0] T_ILL = 2'b10;

  logic [1:0]                 state_q, state_d;
  logic [CW-1:0]              col_q, col_d;
  logic [D-1:0][W-1:0]        vec_q;
  logic [D-1:0][D-1:0][1:0]   mat_q;
  logic                       illegal_q;
  logic [D-1:0]               ill_col;
  logic                       accept;
  logic                       last_col;
  logic [W-1:0]               v_col;
  logic signed [AW-1:0]       v_ext;

  assign accept   = in_valid_i && in_ready_o;
  assign last_col = (state_q == S_ACCUM) && (col_q == CW'(D - 1));
  assign v_col    = vec_q[col_q];
  assign v_ext    = {{(AW - W){v_col[W-1]}}, v_col};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid_i)  state_d = S_ACCUM;
      S_ACCUM: if (last_col)    state_d = S_DONE;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_DONE);
  end

  always_comb begin
    col_d = col_q;
    if (accept)                                col_d = '0;
    else if (state_q == S_ACCUM && !last_col)  col_d = col_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q     <= '0;
      vec_q     <= '0;
      mat_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      illegal_q <= illegal_q | (|ill_col);
      if (accept) begin
        vec_q <= in_vector_i;
        mat_q <= in_matrix_i;
      end
    end
  end

  assign illegal_o = illegal_q;

  for (genvar i = 0; i < D; i++) begin : g_row
    logic [1:0]           trit;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [W-1:0]         res;
    logic [W-1:0]         out_q;

    assign trit       = mat_q[col_q][i];
    assign ill_col[i] = (state_q == S_ACCUM) && (trit == T_ILL);

    always_comb begin
      acc_d = acc_q;
      if (trit == T_POS)      acc_d = acc_q + v_ext;
      else if (trit == T_NEG) acc_d = acc_q - v_ext;
    end

    if (Saturate) begin : g_sat
      localparam logic signed [AW-1:0] SAT_MAX = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
      localparam logic signed [AW-1:0] SAT_MIN = {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};
      always_comb begin
        if (acc_d > SAT_MAX)      res = SAT_MAX[W-1:0];
        else if (acc_d < SAT_MIN) res = SAT_MIN[W-1:0];
        else                      res = acc_d[W-1:0];
      end
    end else begin : g_wrap
      assign res = acc_d[W-1:0];
    end

    // The result register is loaded from the final column's sum on the ACCUM->DONE edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        acc_q <= '0;
        out_q <= '0;
      end else begin
        if (accept)                  acc_q <= '0;
        else if (state_q == S_ACCUM) acc_q <= acc_d;
        if (last_col)                out_q <= res;
      end
    end

    assign out_vector_o[i] = out_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ternary_matvec_engine.sv
// Directed bench for ternary_matvec_engine (D=4, 16-bit Q8.8 fixed point).
`default_nettype none

module tb_ternary_matvec_engine;

  localparam int D = 4;
  localparam int W = 16;

  typedef logic [D-1:0][W-1:0]      vec_t;
  typedef logic [D-1:0][D-1:0][1:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  vec_t in_vector = '0;
  mat_t in_matrix = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  vec_t out_vector;
  logic illegal;

  int checks = 0;
  int failures = 0;

  ternary_matvec_engine #(.D(D), .Saturate(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_vector_i  (in_vector),
    .in_matrix_i  (in_matrix),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_vector_o (out_vector),
    .illegal_o    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: integer sum of +/-v[j] per row, clamped to the 16-bit range.
  function automatic vec_t model(input vec_t v, input mat_t m);
    vec_t r;
    for (int i = 0; i < D; i++) begin
      int s = 0;
      for (int j = 0; j < D; j++) begin
        if (m[j][i] == 2'b01)      s = s + int'($signed(v[j]));
        else if (m[j][i] == 2'b11) s = s - int'($signed(v[j]));
      end
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      r[i] = s[15:0];
    end
    return r;
  endfunction

  // Drives one operand pair with out_ready high; lat counts the handshake cycle as 1.
  task automatic do_op(input vec_t v, input mat_t m, output int lat, output vec_t res,
                       output bit ready_low);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_vector = v;
    in_matrix = m;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_vector = ~v;
    in_matrix = ~m;
    lat = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = out_vector;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_vector !== '0) begin failures++; $display("FAIL reset_out_vector got=%h exp=0", out_vector); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity();
    vec_t v, res; mat_t m; int lat; bit rl;
    v = {16'h0300, 16'h0040, 16'hFD80, 16'h0100};
    m = '0;
    for (int k = 0; k < D; k++) m[k][k] = 2'b01;
    do_op(v, m, lat, res, rl);
    checks++; if (lat !== D + 1) begin failures++; $display("FAIL identity_latency got=%0d exp=%0d", lat, D + 1); end
    checks++; if (res !== v) begin failures++; $display("FAIL identity_result got=%h exp=%h", res, v); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL identity_ready_low got=%b exp=1", rl); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL identity_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sign_skip();
    vec_t v, res, exp; mat_t m; int lat; bit rl;
    v = {16'h0080, 16'h0500, 16'h0200, 16'h0100};
    m = '0;
    m[0][0] = 2'b01; m[1][0] = 2'b11; m[3][0] = 2'b01;
    exp = {16'h0000, 16'h0000, 16'h0000, 16'hFF80};
    do_op(v, m, lat, res, rl);
    checks++; if (res !== exp) begin failures++; $display("FAIL sign_skip_result got=%h exp=%h", res, exp); end
    checks++; if (lat !== D + 1) begin failures++; $display("FAIL sign_skip_latency got=%0d exp=%0d", lat, D + 1); end
  endtask

  task automatic test_saturation();
    vec_t res; int lat; bit rl;
    do_op({4{16'h7FFF}}, {16{2'b01}}, lat, res, rl);
    checks++; if (res !== {4{16'h7FFF}}) begin failures++; $display("FAIL sat_pos_max got=%h exp=%h", res, {4{16'h7FFF}}); end
    do_op({4{16'h8000}}, {16{2'b11}}, lat, res, rl);
    checks++; if (res !== {4{16'h7FFF}}) begin failures++; $display("FAIL sat_neg_min got=%h exp=%h", res, {4{16'h7FFF}}); end
    do_op({4{16'h8000}}, {16{2'b01}}, lat, res, rl);
    checks++; if (res !== {4{16'h8000}}) begin failures++; $display("FAIL sat_pos_min got=%h exp=%h", res, {4{16'h8000}}); end
  endtask

  task automatic test_illegal();
    vec_t v, res, exp; mat_t m; int lat; bit rl;
    v = {16'h0080, 16'h0500, 16'h0200, 16'h0100};
    m = '0;
    for (int k = 0; k < D; k++) m[k][k] = 2'b01;
    m[1][1] = 2'b10;
    exp = {16'h0080, 16'h0500, 16'h0000, 16'h0100};
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_before got=%b exp=0", illegal); end
    do_op(v, m, lat, res, rl);
    checks++; if (res !== exp) begin failures++; $display("FAIL illegal_result got=%h exp=%h", res, exp); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_set got=%b exp=1", illegal); end
    m[1][1] = 2'b01;
    do_op(v, m, lat, res, rl);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", illegal); end
  endtask

  task automatic test_back_to_back();
    vec_t v, held, exp; mat_t m; int n;
    vec_t rv[3]; mat_t rm[3]; vec_t results[4]; int hs_cyc[3];
    int cyc, k, got; bit hs, ohs;
    v = {16'h0080, 16'h0500, 16'h0200, 16'h0100};
    m = '0;
    m[0][0] = 2'b01; m[1][0] = 2'b11; m[3][0] = 2'b01;
    exp = {16'h0000, 16'h0000, 16'h0000, 16'hFF80};
    @(negedge clk);
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_vector = v; in_matrix = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_vector = ~v; in_matrix = {16{2'b01}};
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    held = out_vector;
    checks++; if (held !== exp) begin failures++; $display("FAIL bp_result got=%h exp=%h", held, exp); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vector !== exp) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b out=%h exp valid=1 ready=0 out=%h",
                 c, out_valid, in_ready, out_vector, exp);
      end
    end
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < D; j++) rv[p][j] = 16'($urandom);
      for (int j = 0; j < D; j++)
        for (int i = 0; i < D; i++) begin
          int r = int'($urandom_range(0, 2));
          rm[p][j][i] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        end
    end
    in_vector = rv[0]; in_matrix = rm[0]; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; k = 0; got = 0;
    while ((k < 3 || got < 4) && cyc < 200) begin
      hs  = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (ohs) begin results[got] = out_vector; got++; end
      if (hs) begin hs_cyc[k] = cyc; k++; end
      @(posedge clk); #1;
      if (hs) begin
        if (k < 3) begin in_vector = rv[k]; in_matrix = rm[k]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (k !== 3 || got !== 4) begin
      failures++; $display("FAIL b2b_count got hs=%0d res=%0d exp hs=3 res=4", k, got);
    end else begin
      checks++; if (results[0] !== exp) begin failures++; $display("FAIL b2b_held got=%h exp=%h", results[0], exp); end
      for (int p = 0; p < 3; p++) begin
        checks++; if (results[p+1] !== model(rv[p], rm[p])) begin
          failures++; $display("FAIL b2b_result%0d got=%h exp=%h", p, results[p+1], model(rv[p], rm[p]));
        end
      end
      for (int p = 1; p < 3; p++) begin
        checks++; if (hs_cyc[p] - hs_cyc[p-1] !== D + 2) begin
          failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", p, hs_cyc[p] - hs_cyc[p-1], D + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v, v2, res; mat_t m, m2; int n, lat; bit rl, seen;
    v = {16'h0300, 16'h0040, 16'hFD80, 16'h0100};
    m = {16{2'b01}};
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_vector = v; in_matrix = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_vector !== '0) begin failures++; $display("FAIL rstmid_out_vector got=%h exp=0", out_vector); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL rstmid_illegal got=%b exp=0", illegal); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (D + 4) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_result got=%b exp=0", seen); end
    v2 = {16'h0100, 16'hFF00, 16'h0280, 16'h0040};
    m2 = '0;
    m2[0][0] = 2'b01; m2[1][0] = 2'b01; m2[2][1] = 2'b11; m2[3][2] = 2'b01; m2[0][3] = 2'b11; m2[3][3] = 2'b11;
    do_op(v2, m2, lat, res, rl);
    checks++; if (res !== model(v2, m2)) begin failures++; $display("FAIL rstmid_next got=%h exp=%h", res, model(v2, m2)); end
    checks++; if (lat !== D + 1) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, D + 1); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_sign_skip();
    test_saturation();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
